gpu_rect_scan_ctrl: RTL and testbench

Sequencer for the pixel-pair scanner datapath when it renders rectangles and FILL primitives.
- Latches an inclusive bounding box on a start pulse.
- Drives the scanner's load/select controls to walk the box row by row, left to right, two pixels per step.
- Offers each pair to the pixel pipeline with a valid/ready handshake, then pulses done.
- Sits between the GPU command FSM and the scanner.

---
 rtl/gpu_rect_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_gpu_rect_scan_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gpu_rect_scan_ctrl.sv
// Rectangle/FILL scan sequencer: walks an inclusive bounding box two pixels per step,
// driving the pixel-pair scanner and offering each pair over a valid/ready handshake.

package gpu_rect_scan_pkg;
  typedef enum logic [1:0] {
    X_HOLD       = 2'd0,
    X_TRI_BBLEFT = 2'd1,
    X_TRI_NEXT   = 2'd2
  } nextX_t;

  typedef enum logic [1:0] {
    Y_HOLD      = 2'd0,
    Y_TRI_START = 2'd1,
    Y_TRI_NEXT  = 2'd2
  } nextY_t;
endpackage

module gpu_rect_scan_ctrl
  import gpu_rect_scan_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_interlace,
  input  logic signed [11:0] i_minX,
  input  logic signed [11:0] i_minY,
  input  logic signed [11:0] i_maxX,
  input  logic signed [11:0] i_maxY,
  output logic signed [11:0] o_bbMinX,
  output logic signed [11:0] o_bbMinY,
  output logic signed [11:0] o_bbMaxX,
  input  logic signed [11:0] i_pixelX,
  input  logic signed [11:0] i_pixelY,
  output logic               o_loadNext,
  output nextX_t             o_selNextX,
  output nextY_t             o_selNextY,
  output logic               o_tri_resetDir,
  output logic               o_pairValid,
  input  logic               i_pairReady,
  output logic [1:0]         o_pairMask,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {StIdle, StLoad, StScan, StDone} state_t;

  state_t             r_state;
  state_t             w_state_d;
  logic signed [11:0] r_bbMinX, r_bbMinY, r_bbMaxX, r_bbMaxY;
  logic               w_accept;
  logic               w_empty;

  // 13-bit signed views so the step/compare arithmetic can never wrap
  logic signed [12:0] w_px13, w_py13, w_nx, w_ny, w_x1;
  logic signed [12:0] w_minX13, w_maxX13, w_maxY13;

  assign w_accept = (r_state == StIdle) && i_start && !i_abort;
  assign w_empty  = (i_minX > i_maxX) || (i_minY > i_maxY);

  assign w_px13   = $signed({i_pixelX[11], i_pixelX});
  assign w_py13   = $signed({i_pixelY[11], i_pixelY});
  assign w_minX13 = $signed({r_bbMinX[11], r_bbMinX});
  assign w_maxX13 = $signed({r_bbMaxX[11], r_bbMaxX});
  assign w_maxY13 = $signed({r_bbMaxY[11], r_bbMaxY});
  assign w_nx     = w_px13 + 13'sd2;
  assign w_x1     = w_px13 + 13'sd1;
  assign w_ny     = w_py13 + (i_interlace ? 13'sd2 : 13'sd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_bbMinX <= '0;
      r_bbMinY <= '0;
      r_bbMaxX <= '0;
      r_bbMaxY <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_bbMinX <= i_minX;
        r_bbMinY <= i_minY;
        r_bbMaxX <= i_maxX;
        r_bbMaxY <= i_maxY;
      end
    end
  end

  always_comb begin
    w_state_d      = r_state;
    o_loadNext     = 1'b0;
    o_selNextX     = X_HOLD;
    o_selNextY     = Y_HOLD;
    o_tri_resetDir = 1'b0;
    o_pairValid    = 1'b0;
    o_pairMask     = 2'b00;
    o_done         = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_d = w_empty ? StDone : StLoad;
      end
      StLoad: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else begin
          o_loadNext     = 1'b1;
          o_tri_resetDir = 1'b1;
          o_selNextX     = X_TRI_BBLEFT;
          o_selNextY     = Y_TRI_START;
          w_state_d      = StScan;
        end
      end
      StScan: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (w_py13 > w_maxY13) begin
          // interlace field offset pushed the first row past the box
          w_state_d = StDone;
        end else begin
          o_pairValid   = 1'b1;
          o_pairMask[0] = (w_px13 >= w_minX13) && (w_px13 <= w_maxX13);
          o_pairMask[1] = (w_x1 >= w_minX13) && (w_x1 <= w_maxX13);
          if (i_pairReady) begin
            if (w_nx <= w_maxX13) begin
              o_loadNext = 1'b1;
              o_selNextX = X_TRI_NEXT;
            end else if (w_ny <= w_maxY13) begin
              o_loadNext = 1'b1;
              o_selNextX = X_TRI_BBLEFT;
              o_selNextY = Y_TRI_NEXT;
            end else begin
              w_state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else begin
          o_done    = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_busy   = (r_state != StIdle);
  assign o_bbMinX = r_bbMinX;
  assign o_bbMinY = r_bbMinY;
  assign o_bbMaxX = r_bbMaxX;

endmodule

// File: tb/tb_gpu_rect_scan_ctrl.sv
// Bench for gpu_rect_scan_ctrl: a behavioural scanner drives pixel feedback, and a
// loop-based reference model predicts the ordered pair list for each box.
module tb_gpu_rect_scan_ctrl;
  import gpu_rect_scan_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start, i_abort, i_interlace, i_pairReady;
  logic signed [11:0] i_minX, i_minY, i_maxX, i_maxY;
  logic signed [11:0] o_bbMinX, o_bbMinY, o_bbMaxX;
  logic signed [11:0] px, py;
  logic               o_loadNext, o_tri_resetDir, o_pairValid, o_busy, o_done;
  nextX_t             o_selNextX;
  nextY_t             o_selNextY;
  logic [1:0]         o_pairMask;

  int n_checks = 0;
  int n_errors = 0;
  int field_off = 1;

  always #5 clk = ~clk;

  gpu_rect_scan_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_interlace(i_interlace), .i_minX(i_minX), .i_minY(i_minY), .i_maxX(i_maxX),
    .i_maxY(i_maxY), .o_bbMinX(o_bbMinX), .o_bbMinY(o_bbMinY), .o_bbMaxX(o_bbMaxX),
    .i_pixelX(px), .i_pixelY(py), .o_loadNext(o_loadNext), .o_selNextX(o_selNextX),
    .o_selNextY(o_selNextY), .o_tri_resetDir(o_tri_resetDir), .o_pairValid(o_pairValid),
    .i_pairReady(i_pairReady), .o_pairMask(o_pairMask), .o_busy(o_busy), .o_done(o_done)
  );

  // Scanner model: registered position, updated only on a load strobe
  always @(posedge clk) begin
    if (rst) begin
      px <= '0;
      py <= '0;
    end else if (o_loadNext) begin
      case (o_selNextX)
        X_TRI_BBLEFT: px <= o_bbMinX & 12'shFFE;
        X_TRI_NEXT:   px <= px + 12'sd2;
        default:      px <= px;
      endcase
      case (o_selNextY)
        Y_TRI_START: py <= o_bbMinY + (i_interlace ? 12'(field_off) : 12'sd0);
        Y_TRI_NEXT:  py <= py + (i_interlace ? 12'sd2 : 12'sd1);
        default:     py <= py;
      endcase
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready
  task automatic run_box(input int mnx, input int mny, input int mxx, input int mxy,
                         input bit il, input int mode, input int abort_at);
    int  ex[$], ey[$], em[$];
    int  hs = 0, last_hs = 0, exp_n, p = 0, first_k = -1;
    bit  empty, finished = 0, do_abort, prev_stall = 0;
    int  prev_x = 0, prev_y = 0, prev_m = 0;
    bit  pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    empty = (mnx > mxx) || (mny > mxy);
    if (!empty) begin
      for (int y = mny + (il ? field_off : 0); y <= mxy; y += (il ? 2 : 1)) begin
        for (int x = mnx & ~1; x <= mxx; x += 2) begin
          ex.push_back(x);
          ey.push_back(y);
          em.push_back(((x >= mnx && x <= mxx) ? 1 : 0) |
                       ((x + 1 >= mnx && x + 1 <= mxx) ? 2 : 0));
        end
      end
    end
    exp_n = ex.size();

    @(negedge clk);
    i_minX = 12'(mnx); i_minY = 12'(mny); i_maxX = 12'(mxx); i_maxY = 12'(mxy);
    i_interlace = il; i_start = 1'b1; i_abort = 1'b0; i_pairReady = 1'b0;

    for (int k = 1; k <= 500 && !finished; k++) begin
      @(negedge clk);
      i_start = ($urandom_range(0, 7) == 0);  // stray starts while busy must be ignored
      i_minX = 12'($urandom); i_minY = 12'($urandom);
      i_maxX = 12'($urandom); i_maxY = 12'($urandom);
      if (mode == 0) i_pairReady = 1'b1;
      else if (mode == 1) begin i_pairReady = pat[p % 4]; if (k >= 2) p++; end
      else i_pairReady = $urandom_range(0, 1);
      do_abort = (abort_at >= 0) && (hs == abort_at) && (k >= 2);
      i_abort  = do_abort;
      #1;
      if (k == 1) begin
        check("bb_minx", int'(o_bbMinX), mnx);
        check("bb_miny", int'(o_bbMinY), mny);
        check("bb_maxx", int'(o_bbMaxX), mxx);
        if (!empty) begin
          check("load_strobe", int'(o_loadNext), 1);
          check("load_resetdir", int'(o_tri_resetDir), 1);
          check("load_selx", int'(o_selNextX), int'(X_TRI_BBLEFT));
          check("load_sely", int'(o_selNextY), int'(Y_TRI_START));
        end
      end
      if (do_abort) begin
        check("abort_load", int'(o_loadNext), 0);
        check("abort_done", int'(o_done), 0);
        @(negedge clk);
        i_abort = 1'b0; i_start = 1'b0; i_pairReady = 1'b0;
        #1;
        check("abort_busy", int'(o_busy), 0);
        check("abort_nodone", int'(o_done), 0);
        return;
      end
      if (o_done) begin
        finished = 1;
        check("pair_count", hs, exp_n);
        if (empty) check("empty_done_cycle", k, 1);
        else if (exp_n > 0) check("done_latency", k, last_hs + 1);
        check("done_noload", int'(o_loadNext), 0);
      end else if (o_pairValid) begin
        if (first_k < 0) begin
          first_k = k;
          check("first_valid_cycle", k, 2);
        end
        if (prev_stall) begin
          check("stall_x", int'(px), prev_x);
          check("stall_y", int'(py), prev_y);
          check("stall_mask", int'(o_pairMask), prev_m);
        end
        if (!i_pairReady) check("stall_noload", int'(o_loadNext), 0);
        else if (ex.size() == 0) check("extra_pair", 1, 0);
        else begin
          check("pair_x", int'(px), ex.pop_front());
          check("pair_y", int'(py), ey.pop_front());
          check("pair_mask", int'(o_pairMask), em.pop_front());
          hs++;
          last_hs = k;
        end
        prev_stall = !i_pairReady;
        prev_x = int'(px); prev_y = int'(py); prev_m = int'(o_pairMask);
      end else begin
        if (prev_stall) check("valid_dropped", 0, 1);
        if (k >= 2) check("idle_noload", int'(o_loadNext), 0);
        prev_stall = 0;
      end
    end
    if (!finished) check("done_timeout", 0, 1);
    @(negedge clk);
    i_start = 1'b0; i_pairReady = 1'b0;
    #1;
    check("post_done_busy", int'(o_busy), 0);
    check("post_done_pulse", int'(o_done), 0);
  endtask

  initial begin
    rst = 1'b1; i_start = 0; i_abort = 0; i_interlace = 0; i_pairReady = 0;
    i_minX = '0; i_minY = '0; i_maxX = '0; i_maxY = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(o_busy), 0);
    check("rst_valid", int'(o_pairValid), 0);
    check("rst_load", int'(o_loadNext), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_bbminx", int'(o_bbMinX), 0);
    check("rst_selx", int'(o_selNextX), int'(X_HOLD));
    check("rst_sely", int'(o_selNextY), int'(Y_HOLD));
    rst = 1'b0;

    run_box(3, 10, 6, 11, 0, 0, -1);
    run_box(3, 10, 6, 11, 0, 1, -1);
    run_box(0, 10, 3, 15, 1, 2, -1);
    run_box(5, 0, 4, 3, 0, 0, -1);
    run_box(3, 10, 6, 11, 0, 0, 2);
    run_box(3, 10, 6, 11, 0, 0, -1);
    run_box(-3, -1, 0, -1, 0, 0, -1);
    run_box(2, 10, 4, 10, 1, 0, -1);

    // start and abort together in idle: abort wins
    @(negedge clk);
    i_minX = 12'sd1; i_maxX = 12'sd2; i_minY = 12'sd1; i_maxY = 12'sd1;
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    #1;
    check("start_abort_busy", int'(o_busy), 0);

    // reset mid-operation returns outputs to reset values
    run_box(3, 10, 6, 11, 0, 0, -1);
    @(negedge clk);
    i_minX = 12'sd0; i_maxX = 12'sd9; i_minY = 12'sd0; i_maxY = 12'sd3;
    i_start = 1'b1; i_pairReady = 1'b1;
    repeat (3) @(negedge clk);
    i_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_valid", int'(o_pairValid), 0);
    check("midrst_bbmaxx", int'(o_bbMaxX), 0);
    check("midrst_selx", int'(o_selNextX), int'(X_HOLD));
    rst = 1'b0;

    for (int t = 0; t < 12; t++) begin
      int mnx, mny;
      mnx = $urandom_range(0, 40) - 20;
      mny = $urandom_range(0, 20) - 10;
      run_box(mnx, mny, mnx + $urandom_range(0, 10) - 1, mny + $urandom_range(0, 5) - 1,
              $urandom_range(0, 1), 2, (t % 4 == 3) ? 1 : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
